// File: rtl/uart_term_tx_if.sv
// Byte write handshake into the UART transmitter FIFO.
// The transmitter presents its FIFO-not-full status on wr_ready.
interface uart_term_tx_if;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;

   modport master (output wr_data, output wr_valid, input wr_ready);
   modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_term_tx.sv
// 8N1 UART transmitter with a small byte FIFO and an internal baud counter.
// The line output and all status outputs come straight from flops.
module uart_term_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        HCLK,
   input  logic                        HRESET,
   uart_term_tx_if.slave               wr,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [1:0]    state_r, state_s;
   logic [BW-1:0] baud_r, baud_s;
   logic [2:0]    bit_idx_r, bit_idx_s;
   logic [7:0]    shift_r, shift_s;
   logic          tx_r, tx_s;
   logic          busy_r, busy_s;
   logic [CW-1:0] count_r, count_s;
   logic          wr_ready_r;
   logic [PW-1:0] rd_ptr_r, wr_ptr_r;
   logic [7:0]    mem_r [FIFO_DEPTH];
   logic          push_s, pop_s, baud_end_s, fifo_empty_s;

   assign push_s       = wr.wr_valid & wr_ready_r;
   assign baud_end_s   = (baud_r == BAUD_LAST);
   assign fifo_empty_s = (count_r == CW'(0));
   assign count_s      = count_r + CW'(push_s) - CW'(pop_s);

   // Frame sequencer; tx is decoded from the next state so the line flop never glitches.
   always_comb begin
      state_s   = state_r;
      baud_s    = baud_r;
      bit_idx_s = bit_idx_r;
      shift_s   = shift_r;
      pop_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            baud_s = BW'(0);
            if (!fifo_empty_s) begin
               pop_s     = 1'b1;
               shift_s   = mem_r[rd_ptr_r];
               bit_idx_s = 3'd0;
               state_s   = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_end_s) begin
               baud_s  = BW'(0);
               state_s = ST_DATA;
            end else begin
               baud_s = baud_r + BW'(1);
            end
         end
         ST_DATA: begin
            if (baud_end_s) begin
               baud_s    = BW'(0);
               shift_s   = {1'b0, shift_r[7:1]};
               bit_idx_s = bit_idx_r + 3'd1;
               if (bit_idx_r == 3'd7) begin
                  state_s = ST_STOP;
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               baud_s = baud_r + BW'(1);
            end
         end
         ST_STOP: begin
            if (baud_end_s) begin
               baud_s = BW'(0);
               // Back-to-back frames: reload straight into START without an idle cycle.
               if (!fifo_empty_s) begin
                  pop_s     = 1'b1;
                  shift_s   = mem_r[rd_ptr_r];
                  bit_idx_s = 3'd0;
                  state_s   = ST_START;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               baud_s = baud_r + BW'(1);
            end
         end
         default: begin
            baud_s  = BW'(0);
            state_s = ST_IDLE;
         end
      endcase

      case (state_s)
         ST_START: tx_s = 1'b0;
         ST_DATA:  tx_s = shift_s[0];
         default:  tx_s = 1'b1;
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State, pointers and registered outputs; reset abandons any frame and empties the FIFO.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r    <= ST_IDLE;
         baud_r     <= BW'(0);
         bit_idx_r  <= 3'd0;
         shift_r    <= 8'd0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         count_r    <= CW'(0);
         wr_ready_r <= 1'b1;
         rd_ptr_r   <= PW'(0);
         wr_ptr_r   <= PW'(0);
      end else begin
         state_r    <= state_s;
         baud_r     <= baud_s;
         bit_idx_r  <= bit_idx_s;
         shift_r    <= shift_s;
         tx_r       <= tx_s;
         busy_r     <= busy_s;
         count_r    <= count_s;
         wr_ready_r <= (count_s != COUNT_FULL);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // FIFO storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge HCLK) begin
      if (push_s && !HRESET) begin
         mem_r[wr_ptr_r] <= wr.wr_data;
      end
   end

   assign tx          = tx_r;
   assign busy        = busy_r;
   assign fifo_count  = count_r;
   assign wr.wr_ready = wr_ready_r;

endmodule

// File: tb/tb_uart_term_tx.sv
// Directed bench for uart_term_tx: one 16-clock-per-bit instance and one 2-clock-per-bit instance.
module tb_uart_term_tx;

   logic HCLK = 1'b0;
   logic HRESET;
   always #5 HCLK = ~HCLK;

   uart_term_tx_if if16 ();
   uart_term_tx_if if2 ();

   logic       wv;
   logic [7:0] wd;
   logic       sel;

   assign if16.wr_valid = wv & ~sel;
   assign if16.wr_data  = wd;
   assign if2.wr_valid  = wv & sel;
   assign if2.wr_data   = wd;

   logic       tx16, busy16, tx2, busy2;
   logic [2:0] cnt16, cnt2;

   uart_term_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut16 (
      .HCLK(HCLK), .HRESET(HRESET), .wr(if16),
      .tx(tx16), .busy(busy16), .fifo_count(cnt16)
   );

   uart_term_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
      .HCLK(HCLK), .HRESET(HRESET), .wr(if2),
      .tx(tx2), .busy(busy2), .fifo_count(cnt2)
   );

   logic       tx_m, busy_m, ready_m;
   logic [2:0] cnt_m;
   assign tx_m    = sel ? tx2 : tx16;
   assign busy_m  = sel ? busy2 : busy16;
   assign ready_m = sel ? if2.wr_ready : if16.wr_ready;
   assign cnt_m   = sel ? cnt2 : cnt16;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge HCLK);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      wd = d;
      wv = 1'b1;
      tick;
      wv = 1'b0;
   endtask

   // Walks one frame cycle by cycle from offset 'first'; optionally writes a byte on the last cycle.
   task automatic check_frame(input string tag, input logic [7:0] data, input int cpb,
                              input int first, input bit push_last, input logic [7:0] push_data);
      int   errs;
      int   bcnt;
      int   slot;
      logic exp_tx;
      errs = 0;
      bcnt = 0;
      for (int c = first; c < 10 * cpb; c++) begin
         slot = c / cpb;
         if (slot == 0)      exp_tx = 1'b0;
         else if (slot == 9) exp_tx = 1'b1;
         else                exp_tx = data[slot-1];
         if (tx_m !== exp_tx) errs++;
         if (busy_m === 1'b1) bcnt++;
         if (push_last && c == 10 * cpb - 1) begin
            wd = push_data;
            wv = 1'b1;
         end
         tick;
         if (push_last) wv = 1'b0;
      end
      check({tag, "_line_errs"}, 32'(errs), 32'd0);
      check({tag, "_busy_cycles"}, 32'(bcnt), 32'(10 * cpb - first));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int errs;
      HRESET = 1'b1;
      wv     = 1'b0;
      wd     = 8'h00;
      sel    = 1'b0;
      tick;
      tick;
      HRESET = 1'b0;

      check("rst_tx16",    32'(tx16), 32'd1);
      check("rst_busy16",  32'(busy16), 32'd0);
      check("rst_cnt16",   32'(cnt16), 32'd0);
      check("rst_ready16", 32'(if16.wr_ready), 32'd1);
      check("rst_tx2",     32'(tx2), 32'd1);
      check("rst_busy2",   32'(busy2), 32'd0);

      // single byte 0x55
      write_byte(8'h55);
      check("s55_cnt_k",  32'(cnt_m), 32'd1);
      check("s55_tx_k",   32'(tx_m), 32'd1);
      check("s55_busy_k", 32'(busy_m), 32'd0);
      tick;
      check("s55_tx_k1",   32'(tx_m), 32'd0);
      check("s55_busy_k1", 32'(busy_m), 32'd1);
      check("s55_cnt_k1",  32'(cnt_m), 32'd0);
      check_frame("s55", 8'h55, 16, 0, 1'b0, 8'h00);
      check("s55_busy_end", 32'(busy_m), 32'd0);
      check("s55_tx_end",   32'(tx_m), 32'd1);

      // "Hi" back to back
      wd = 8'h48;
      wv = 1'b1;
      tick;
      wd = 8'h69;
      tick;
      wv = 1'b0;
      check("hi_cnt",   32'(cnt_m), 32'd1);
      check("hi_tx_st", 32'(tx_m), 32'd0);
      check_frame("hi_H", 8'h48, 16, 0, 1'b0, 8'h00);
      check_frame("hi_i", 8'h69, 16, 0, 1'b0, 8'h00);
      check("hi_busy_end", 32'(busy_m), 32'd0);

      // overflow: A0..A7 held, only A0..A4 survive
      for (int i = 0; i < 8; i++) begin
         wd = 8'hA0 + 8'(i);
         wv = 1'b1;
         tick;
      end
      wv = 1'b0;
      check("ovf_cnt",   32'(cnt_m), 32'd4);
      check("ovf_ready", 32'(ready_m), 32'd0);
      check_frame("ovf_A0", 8'hA0, 16, 6, 1'b0, 8'h00);
      check("ovf_cnt_pop",   32'(cnt_m), 32'd3);
      check("ovf_ready_pop", 32'(ready_m), 32'd1);
      check_frame("ovf_A1", 8'hA1, 16, 0, 1'b0, 8'h00);
      check_frame("ovf_A2", 8'hA2, 16, 0, 1'b0, 8'h00);
      check_frame("ovf_A3", 8'hA3, 16, 0, 1'b0, 8'h00);
      check_frame("ovf_A4", 8'hA4, 16, 0, 1'b0, 8'h00);
      check("ovf_busy_end", 32'(busy_m), 32'd0);
      check("ovf_cnt_end",  32'(cnt_m), 32'd0);

      // push on the same edge as the STOP->START pop
      write_byte(8'hB1);
      write_byte(8'hB2);
      write_byte(8'hB3);
      check("pp_cnt_pre", 32'(cnt_m), 32'd2);
      check_frame("pp_B1", 8'hB1, 16, 1, 1'b1, 8'hB4);
      check("pp_cnt_post", 32'(cnt_m), 32'd2);
      check_frame("pp_B2", 8'hB2, 16, 0, 1'b0, 8'h00);
      check_frame("pp_B3", 8'hB3, 16, 0, 1'b0, 8'h00);
      check_frame("pp_B4", 8'hB4, 16, 0, 1'b0, 8'h00);
      check("pp_busy_end", 32'(busy_m), 32'd0);

      // reset during data bit 3 with three bytes queued
      write_byte(8'h37);
      write_byte(8'hC1);
      write_byte(8'hC2);
      write_byte(8'hC3);
      check("rmf_cnt_pre", 32'(cnt_m), 32'd3);
      repeat (68) tick;
      check("rmf_tx_bit3", 32'(tx_m), 32'd0);
      HRESET = 1'b1;
      wd     = 8'hEE;
      wv     = 1'b1;
      tick;
      HRESET = 1'b0;
      wv     = 1'b0;
      check("rmf_tx",    32'(tx_m), 32'd1);
      check("rmf_busy",  32'(busy_m), 32'd0);
      check("rmf_cnt",   32'(cnt_m), 32'd0);
      check("rmf_ready", 32'(ready_m), 32'd1);
      errs = 0;
      repeat (200) begin
         if (tx_m !== 1'b1 || busy_m !== 1'b0 || cnt_m !== 3'd0) errs++;
         tick;
      end
      check("rmf_quiet_errs", 32'(errs), 32'd0);
      write_byte(8'h0F);
      check("rmf_cnt_new", 32'(cnt_m), 32'd1);
      tick;
      check_frame("rmf_0F", 8'h0F, 16, 0, 1'b0, 8'h00);
      check("rmf_busy_end", 32'(busy_m), 32'd0);

      // two clocks per bit corner
      sel = 1'b1;
      write_byte(8'hFF);
      check("c2_cnt", 32'(cnt_m), 32'd1);
      tick;
      check("c2_tx_st",   32'(tx_m), 32'd0);
      check("c2_busy_st", 32'(busy_m), 32'd1);
      check_frame("c2_FF", 8'hFF, 2, 0, 1'b0, 8'h00);
      check("c2_busy_end", 32'(busy_m), 32'd0);
      check("c2_tx_end",   32'(tx_m), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
